// File: rtl/cpu_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU codes,
// sequencer states, instruction classes and the bundled control word.
package cpu_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALU_W    = 5;

    localparam logic [OPCODE_W-1:0] OP_LD   = 5'd0;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'd2;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'd10;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'd11;
    localparam logic [OPCODE_W-1:0] OP_ADDI = 5'd12;
    localparam logic [OPCODE_W-1:0] OP_ANDI = 5'd13;
    localparam logic [OPCODE_W-1:0] OP_ORI  = 5'd14;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'd26;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'd27;

    localparam logic [ALU_W-1:0] ALU_ADD = 5'd3;
    localparam logic [ALU_W-1:0] ALU_SUB = 5'd4;
    localparam logic [ALU_W-1:0] ALU_AND = 5'd10;
    localparam logic [ALU_W-1:0] ALU_OR  = 5'd11;
    localparam logic [ALU_W-1:0] ALU_INC = 5'd19;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7,
        S_HALT
    } state_e;

    typedef enum logic [2:0] {
        CLS_RTYPE,
        CLS_IMM,
        CLS_LDI,
        CLS_LD,
        CLS_ST,
        CLS_NOP,
        CLS_HALT,
        CLS_ILLEGAL
    } instr_class_e;

    // One bit per datapath strobe, plus the ALU operation for the step.
    typedef struct packed {
        logic             pc_out;
        logic             pc_in;
        logic             pc_increment;
        logic             mar_in;
        logic             mdr_in;
        logic             mdr_out;
        logic             read;
        logic             memory_read;
        logic             memory_write;
        logic             ir_in;
        logic             ry_in;
        logic             zhigh_in;
        logic             zlow_in;
        logic             zlow_out;
        logic             c_out;
        logic             gra;
        logic             grb;
        logic             grc;
        logic             r_in;
        logic             r_out;
        logic             ba_out;
        logic [ALU_W-1:0] alu_control;
    } ctrl_t;

    // ldi, ld and st all form an effective address as Rb (or 0) + C.
    function automatic logic uses_addr_path(input instr_class_e cls);
        return (cls == CLS_LDI) || (cls == CLS_LD) || (cls == CLS_ST);
    endfunction

endpackage

// File: rtl/cu_decoder.sv
// Combinational opcode decoder: maps the latched opcode to an instruction
// class and the ALU operation used in the execute step.
module cu_decoder
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output instr_class_e        instr_class,
    output logic [ALU_W-1:0]    alu_op
);

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        instr_class = CLS_ILLEGAL;
        alu_op      = ALU_ADD;
        case (opcode)
            OP_LD:   instr_class = CLS_LD;
            OP_LDI:  instr_class = CLS_LDI;
            OP_ST:   instr_class = CLS_ST;
            OP_ADD:  instr_class = CLS_RTYPE;
            OP_SUB:  begin instr_class = CLS_RTYPE; alu_op = ALU_SUB; end
            OP_AND:  begin instr_class = CLS_RTYPE; alu_op = ALU_AND; end
            OP_OR:   begin instr_class = CLS_RTYPE; alu_op = ALU_OR;  end
            OP_ADDI: instr_class = CLS_IMM;
            OP_ANDI: begin instr_class = CLS_IMM;   alu_op = ALU_AND; end
            OP_ORI:  begin instr_class = CLS_IMM;   alu_op = ALU_OR;  end
            OP_NOP:  instr_class = CLS_NOP;
            OP_HALT: instr_class = CLS_HALT;
            default: instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the Mini SRC datapath: steps T0..T7 one per
// clock and drives every datapath strobe from the state and latched opcode.
module control_unit
    import cpu_pkg::*;
#(
    parameter bit STOP_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      ir,
    input  logic             stop,
    output logic             run,
    output logic             PCout,
    output logic             PCin,
    output logic             pc_increment,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             read,
    output logic             memoryRead,
    output logic             memoryWrite,
    output logic             IRin,
    output logic             RYin,
    output logic             Zhighin,
    output logic             Zlowin,
    output logic             Zlowout,
    output logic             Cout,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin,
    output logic             Rout,
    output logic             BAout,
    output logic [ALU_W-1:0] alu_control
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q;
    logic                stop_q;
    instr_class_e        dec_class;
    instr_class_e        cls;
    logic [ALU_W-1:0]    alu_op;
    ctrl_t               ctrl;
    logic                unused_ir;

    // Only the opcode field matters here; operand fields go to the datapath.
    assign unused_ir = ^ir[26:0];

    cu_decoder u_decoder (
        .opcode      (opcode_q),
        .instr_class (dec_class),
        .alu_op      (alu_op)
    );

    assign cls = (dec_class != CLS_ILLEGAL) ? dec_class
               : (STOP_ON_ILLEGAL ? CLS_HALT : CLS_NOP);

    // NOTE: sequential state uses non-blocking assignments and an asynchronous
    // active-low clear, so state (and hence every strobe) drops as soon as clr falls.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q  <= S_RESET;
            opcode_q <= '0;
            stop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_T2) opcode_q <= ir[31:27];
            if (state_q == S_T0) stop_q   <= stop;
        end
    end

    // A finished instruction returns to fetch unless a stop was seen in its T0.
    state_e done_state;
    assign done_state = stop_q ? S_HALT : S_T0;

    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        run     = 1'b1;
        case (state_q)
            S_RESET: begin
                run     = 1'b0;
                state_d = S_T0;
            end
            S_T0: begin
                ctrl.pc_out       = 1'b1;
                ctrl.mar_in       = 1'b1;
                ctrl.pc_increment = 1'b1;
                ctrl.zlow_in      = 1'b1;
                ctrl.zhigh_in     = 1'b1;
                ctrl.alu_control  = ALU_INC;
                state_d           = S_T1;
            end
            S_T1: begin
                ctrl.zlow_out    = 1'b1;
                ctrl.pc_in       = 1'b1;
                ctrl.read        = 1'b1;
                ctrl.memory_read = 1'b1;
                ctrl.mdr_in      = 1'b1;
                state_d          = S_T2;
            end
            S_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
                state_d      = S_T3;
            end
            S_T3: begin
                case (cls)
                    CLS_RTYPE, CLS_IMM: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.ry_in = 1'b1;
                        state_d    = S_T4;
                    end
                    CLS_LDI, CLS_LD, CLS_ST: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.ry_in  = 1'b1;
                        state_d     = S_T4;
                    end
                    CLS_NOP: state_d = done_state;
                    default: state_d = S_HALT;
                endcase
            end
            S_T4: begin
                ctrl.zlow_in     = 1'b1;
                ctrl.zhigh_in    = 1'b1;
                ctrl.alu_control = uses_addr_path(cls) ? ALU_ADD : alu_op;
                if (cls == CLS_RTYPE) begin
                    ctrl.grc   = 1'b1;
                    ctrl.r_out = 1'b1;
                end else begin
                    ctrl.c_out = 1'b1;
                end
                state_d = S_T5;
            end
            S_T5: begin
                ctrl.zlow_out = 1'b1;
                if (cls == CLS_LD || cls == CLS_ST) begin
                    ctrl.mar_in = 1'b1;
                    state_d     = S_T6;
                end else begin
                    ctrl.gra  = 1'b1;
                    ctrl.r_in = 1'b1;
                    state_d   = done_state;
                end
            end
            S_T6: begin
                ctrl.mdr_in = 1'b1;
                if (cls == CLS_ST) begin
                    ctrl.gra   = 1'b1;
                    ctrl.r_out = 1'b1;
                end else begin
                    ctrl.read        = 1'b1;
                    ctrl.memory_read = 1'b1;
                end
                state_d = S_T7;
            end
            S_T7: begin
                if (cls == CLS_ST) begin
                    ctrl.memory_write = 1'b1;
                end else begin
                    ctrl.mdr_out = 1'b1;
                    ctrl.gra     = 1'b1;
                    ctrl.r_in    = 1'b1;
                end
                state_d = done_state;
            end
            S_HALT: run = 1'b0;
            default: begin
                run     = 1'b0;
                state_d = S_RESET;
            end
        endcase
    end

    assign PCout        = ctrl.pc_out;
    assign PCin         = ctrl.pc_in;
    assign pc_increment = ctrl.pc_increment;
    assign MARin        = ctrl.mar_in;
    assign MDRin        = ctrl.mdr_in;
    assign MDRout       = ctrl.mdr_out;
    assign read         = ctrl.read;
    assign memoryRead   = ctrl.memory_read;
    assign memoryWrite  = ctrl.memory_write;
    assign IRin         = ctrl.ir_in;
    assign RYin         = ctrl.ry_in;
    assign Zhighin      = ctrl.zhigh_in;
    assign Zlowin       = ctrl.zlow_in;
    assign Zlowout      = ctrl.zlow_out;
    assign Cout         = ctrl.c_out;
    assign Gra          = ctrl.gra;
    assign Grb          = ctrl.grb;
    assign Grc          = ctrl.grc;
    assign Rin          = ctrl.r_in;
    assign Rout         = ctrl.r_out;
    assign BAout        = ctrl.ba_out;
    assign alu_control  = ctrl.alu_control;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired, Moore-style control sequencer for the Mini SRC datapath.
- Sits directly upstream of the datapath: it drives every datapath control strobe that is currently hand-sequenced in benches.
- Reads the instruction register and steps the fetch/decode/execute micro-sequence (T0..T7), one step per clock.
- Supports: ld, ldi, st, R-type ALU ops, immediate ALU ops, nop, halt.

Parameters:
- STOP_ON_ILLEGAL, 1, 1 = an unrecognised opcode enters HALT; 0 = it is treated as nop.

Ports:
- clk  in  1  system clock; datapath samples strobes on posedge.
- clr  in  1  asynchronous, active-low reset.
- ir  in  32  instruction register contents; opcode = ir[31:27].
- stop  in  1  synchronous halt request, sampled only in T0.
- run  out  1  1 while sequencing; 0 in HALT.
- PCout, PCin, pc_increment, MARin  out  1 each  PC/MAR strobes.
- MDRin, MDRout, read, memoryRead, memoryWrite  out  1 each  memory-path strobes; read=1 selects memory into MDR, read=0 selects bus.
- IRin, RYin, Zhighin, Zlowin, Zlowout, Cout  out  1 each  datapath register strobes.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register-select logic strobes.
- alu_control  out  5  ALU operation code.

Behaviour:
- States: RESET, T0..T7, HALT. Outputs are a pure function of state and the latched opcode; each state lasts exactly one clk.
- Reset (clr=0, asynchronous): state=RESET, every output 0 except run=0, alu_control=0. First posedge after release moves RESET to T0 with run=1.
- T0: PCout, MARin, pc_increment, Zlowin, Zhighin; alu_control=ALU_INC (19).
- T1: Zlowout, PCin, read, memoryRead, MDRin.
- T2: MDRout, IRin.
- Opcode is latched from ir at the end of T2. It must not be re-read afterwards, so later IR changes have no effect until the next fetch.
- R-type: T3 Grb+Rout+RYin; T4 Grc+Rout+Zin, alu_control=op code; T5 Zlowout+Gra+Rin; then T0.
- Immediate: T3 Grb+Rout+RYin; T4 Cout+Zin, alu_control=op code; T5 Zlowout+Gra+Rin; then T0.
- ldi: T3 Grb+BAout+RYin; T4 Cout+Zin, ALU_ADD (3); T5 Zlowout+Gra+Rin; then T0.
- ld: T3–T4 as ldi; T5 Zlowout+MARin; T6 read+memoryRead+MDRin; T7 MDRout+Gra+Rin; then T0.
- st: T3–T5 as ld; T6 Gra+Rout+MDRin with read=0; T7 memoryWrite; then T0.
- nop: T3 with all strobes 0; then T0.
- halt: T3 goes to HALT.
- HALT: all strobes 0, run=0. Only clr exits HALT.
- stop=1 sampled in T0 completes the current fetch/execute, then enters HALT from the instruction's last step instead of returning to T0.
- Illegal opcode: handled per STOP_ON_ILLEGAL.
- Zin denotes Zhighin and Zlowin asserted together.
- Reset mid-instruction aborts immediately; no strobe may remain asserted during clr=0.
- Mutual exclusion, guaranteed by construction: at most one bus driver asserted at a time (PCout, Zlowout, MDRout, Rout, Cout, BAout); memoryRead and memoryWrite never both 1.

Decomposition:
- Package cpu_pkg holds:
  - opcode constants (OP_LD=0, OP_LDI=1, OP_ST=2, OP_ADD=3, OP_SUB=4, OP_AND=10, OP_OR=11, OP_ADDI=12, OP_ANDI=13, OP_ORI=14, OP_NOP=26, OP_HALT=27);
  - ALU code constants (ALU_ADD=3, ALU_INC=19, others per ALU);
  - the state enum.
- Sub-module cu_decoder: combinational opcode → {instruction class, alu_control} map.

Test Plan:
- Release clr with ir=addi R5,R6,-7 (0x62B7FFF9) → run=1.
  - T0: PCout=MARin=pc_increment=1, alu_control=19.
  - T2: IRin=1.
  - T4: Cout=1, alu_control=3.
  - T5: Gra=Rin=1.
  - Next state T0 (6 cycles/instruction).
- ir=ld R4,0x54 (0x02000054) → T5 MARin=1; T6 memoryRead=read=MDRin=1; T7 Gra=Rin=1; 8 cycles total.
- ir=st 0x54,R4 (0x12000054) → T6 Rout=MDRin=1 with read=0; T7 memoryWrite=1, memoryRead=0.
- ir=halt (0xD8000000) → HALT after T3, run=0, all strobes 0 for ≥20 cycles; clr pulse → T0 with run=1.
- Assert clr=0 during T4 of an add → all strobes 0 within the same cycle (asynchronous); restart at T0.
- Every cycle of a random opcode stream → assertion that no two bus drivers are asserted together and that memoryRead & memoryWrite == 0.
